// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: shifts address/data bytes on SDA, samples read
// bytes, generates START/STOP line conditions and returns the handshake
// flags (counter, st_ena, stop_done) to the control FSM.
module i2c_bit_engine #(
    parameter int unsigned STOP_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic       scl_n,
    input  logic       scl_p,
    input  logic       sda_in,
    input  logic [6:0] addr_in,
    input  logic       rw_in,
    input  logic [4:0] n_byte,
    input  logic [7:0] tx_data,
    output logic       sda_oe,
    output logic       counter,
    output logic       st_ena,
    output logic       stop_done,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       nack
);

    typedef enum logic [3:0] {
        IDOL       = 4'd0,
        START      = 4'd1,
        ADDRESS    = 4'd2,
        READ_ACK   = 4'd3,
        WRITE      = 4'd4,
        READ       = 4'd5,
        READ_ACK_1 = 4'd6,
        WRITE_ACK  = 4'd7,
        STOP       = 4'd8
    } state_e;

    localparam logic [8:0] HOLD_N = 9'(STOP_HOLD);

    logic [3:0] state_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [4:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       armed_q, armed_d;
    logic       st_ena_q, st_ena_d;
    logic       stop_done_q, stop_done_d;
    logic       nack_q, nack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       tx_req_q, tx_req_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;

    logic entry, in_byte, p_only;

    // A state is "entered" on the first clk the FSM reports it; scl_n beats scl_p.
    assign entry   = (state != state_q);
    assign in_byte = (state == ADDRESS) || (state == WRITE) || (state == READ);
    assign p_only  = scl_p & ~scl_n;

    assign counter   = in_byte && (bit_cnt_q == 3'd7);
    assign sda_oe    = sda_oe_q;
    assign st_ena    = st_ena_q;
    assign stop_done = stop_done_q;
    assign tx_req    = tx_req_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign nack      = nack_q;

    // Next-state for all per-state datapath registers; entry actions win over strobes.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        nack_d      = nack_q;
        st_ena_d    = (state == START) ? st_ena_q : 1'b0;
        stop_done_d = (state == STOP) ? stop_done_q : 1'b0;
        armed_d     = (state == STOP) ? armed_q : 1'b0;
        sda_oe_d    = 1'b0;
        tx_req_d    = 1'b0;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;

        if (!in_byte || entry)
            bit_cnt_d = 3'd0;
        else if (scl_n)
            bit_cnt_d = bit_cnt_q + 3'd1;

        case (state)
            START: begin
                if (entry) begin
                    st_ena_d   = 1'b0;
                    byte_cnt_d = 5'd0;
                    nack_d     = 1'b0;
                end else if (p_only) begin
                    st_ena_d = 1'b1;
                end
                sda_oe_d = st_ena_d;
            end
            ADDRESS, WRITE: begin
                if (entry) begin
                    shift_d  = (state == ADDRESS) ? {addr_in, rw_in} : tx_data;
                    tx_req_d = (state == WRITE);
                end else if (scl_n && bit_cnt_q != 3'd7) begin
                    shift_d = {shift_q[6:0], 1'b0};
                end
                sda_oe_d = ~shift_d[7];
            end
            READ: begin
                if (!entry && p_only)
                    shift_d = {shift_q[6:0], sda_in};
            end
            WRITE_ACK: begin
                if (entry) begin
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    byte_cnt_d = (byte_cnt_q == 5'd31) ? 5'd31 : byte_cnt_q + 5'd1;
                end
                sda_oe_d = (byte_cnt_d != n_byte);
            end
            READ_ACK, READ_ACK_1: begin
                if (p_only && sda_in)
                    nack_d = 1'b1;
            end
            STOP: begin
                if (entry) begin
                    armed_d     = 1'b0;
                    hold_d      = 8'd0;
                    stop_done_d = 1'b0;
                end else if (p_only && !armed_q) begin
                    armed_d = 1'b1;
                    hold_d  = 8'd0;
                end else if (armed_q && !stop_done_q) begin
                    hold_d = hold_q + 8'd1;
                    if ({1'b0, hold_q} + 9'd1 == HOLD_N)
                        stop_done_d = 1'b1;
                end
                sda_oe_d = ~stop_done_d;
            end
            default: ;
        endcase
    end

    // Register bank with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= 4'd0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 5'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            armed_q     <= 1'b0;
            st_ena_q    <= 1'b0;
            stop_done_q <= 1'b0;
            nack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            tx_req_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'd0;
        end else begin
            state_q     <= state;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            armed_q     <= armed_d;
            st_ena_q    <= st_ena_d;
            stop_done_q <= stop_done_d;
            nack_q      <= nack_d;
            sda_oe_q    <= sda_oe_d;
            tx_req_q    <= tx_req_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Directed bench for i2c_bit_engine: drives the control-FSM state and SCL
// strobes by hand and checks SDA drive and handshake flags.
module tb_i2c_bit_engine;

    localparam logic [3:0] S_IDOL = 4'd0, S_START = 4'd1, S_ADDR = 4'd2,
                           S_RACK = 4'd3, S_WR = 4'd4, S_RD = 4'd5,
                           S_RACK1 = 4'd6, S_WACK = 4'd7, S_STOP = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] state = 4'd0;
    logic       scl_n = 1'b0, scl_p = 1'b0, sda_in = 1'b0;
    logic [6:0] addr_in = 7'd0;
    logic       rw_in = 1'b0;
    logic [4:0] n_byte = 5'd0;
    logic [7:0] tx_data = 8'd0;
    logic       sda_oe, counter, st_ena, stop_done, tx_req, rx_valid, nack;
    logic [7:0] rx_data;

    int n_chk = 0;
    int n_fail = 0;
    int tx_cnt = 0;
    int tx_base;

    i2c_bit_engine #(.STOP_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .scl_n(scl_n), .scl_p(scl_p),
        .sda_in(sda_in), .addr_in(addr_in), .rw_in(rw_in), .n_byte(n_byte),
        .tx_data(tx_data), .sda_oe(sda_oe), .counter(counter), .st_ena(st_ena),
        .stop_done(stop_done), .tx_req(tx_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .nack(nack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_req === 1'b1) tx_cnt++;

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // SCL falling strobe; FSM moves to ns on it, entry is the following clk.
    task automatic fall(input logic [3:0] ns);
        scl_n = 1'b1; tick(); scl_n = 1'b0; state = ns; tick();
    endtask

    // SCL rising strobe with the given line level.
    task automatic rise(input logic v);
        sda_in = v; scl_p = 1'b1; tick(); scl_p = 1'b0; tick();
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic [3:0] ns);
        for (int i = 0; i < 8; i++) begin
            chk1({tag, "_sda"}, sda_oe, ~b[7-i]);
            chk1({tag, "_cnt"}, counter, (i == 7));
            rise(1'b0);
            fall((i == 7) ? ns : state);
        end
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] b, input logic [3:0] ns);
        for (int i = 0; i < 8; i++) begin
            chk1({tag, "_sda"}, sda_oe, 1'b0);
            rise(b[7-i]);
            fall((i == 7) ? ns : S_RD);
        end
    endtask

    task automatic start_addr(input logic [6:0] a, input logic rw);
        addr_in = a; rw_in = rw;
        fall(S_START);
        chk1("start_ena0", st_ena, 1'b0);
        chk1("start_sda0", sda_oe, 1'b0);
        rise(1'b1);
        chk1("start_ena1", st_ena, 1'b1);
        chk1("start_sda1", sda_oe, 1'b1);
        fall(S_ADDR);
    endtask

    task automatic do_stop();
        fall(S_STOP);
        chk1("stop_entry_sda", sda_oe, 1'b1);
        chk1("stop_entry_done", stop_done, 1'b0);
        sda_in = 1'b0; scl_p = 1'b1; tick(); scl_p = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk1("stop_hold_done", stop_done, (k == 4));
            chk1("stop_hold_sda", sda_oe, (k != 4));
        end
        rise(1'b1);
        chk1("stop_extra_p", stop_done, 1'b1);
        fall(S_IDOL);
        chk1("idle_done", stop_done, 1'b0);
        chk1("idle_sda", sda_oe, 1'b0);
    endtask

    initial begin
        // Reset values
        tick(2);
        chk1("rst_sda", sda_oe, 1'b0);
        chk1("rst_st_ena", st_ena, 1'b0);
        chk1("rst_stop_done", stop_done, 1'b0);
        chk1("rst_tx_req", tx_req, 1'b0);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk1("rst_nack", nack, 1'b0);
        chk8("rst_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // Write 0x50 address, then bytes 0xA5 and 0x3C, then STOP
        tx_base = tx_cnt;
        start_addr(7'h50, 1'b0);
        send_byte("addr50", 8'hA0, S_RACK);
        rise(1'b0);
        chk1("addr_ack_nack", nack, 1'b0);
        tx_data = 8'hA5;
        fall(S_WR);
        chk1("tx_req_1", tx_req, 1'b1);
        send_byte("wrA5", 8'hA5, S_RACK1);
        rise(1'b0);
        tx_data = 8'h3C;
        fall(S_WR);
        chk1("tx_req_2", tx_req, 1'b1);
        send_byte("wr3C", 8'h3C, S_RACK1);
        rise(1'b0);
        chk1("wr_nack", nack, 1'b0);
        chk8("tx_req_count", 8'(tx_cnt - tx_base), 8'd2);
        do_stop();

        // Read 3 bytes: 0x12, 0x34, 0x56
        n_byte = 5'd3;
        start_addr(7'h50, 1'b1);
        send_byte("addr50r", 8'hA1, S_RACK);
        rise(1'b0);
        fall(S_RD);
        recv_byte("rd12", 8'h12, S_WACK);
        chk1("rx_valid_1", rx_valid, 1'b1);
        chk8("rx_data_1", rx_data, 8'h12);
        chk1("wack_sda_1", sda_oe, 1'b1);
        rise(1'b0);
        chk1("rx_valid_1_off", rx_valid, 1'b0);
        fall(S_RD);
        recv_byte("rd34", 8'h34, S_WACK);
        chk1("rx_valid_2", rx_valid, 1'b1);
        chk8("rx_data_2", rx_data, 8'h34);
        chk1("wack_sda_2", sda_oe, 1'b1);
        rise(1'b0);
        fall(S_RD);
        recv_byte("rd56", 8'h56, S_WACK);
        chk1("rx_valid_3", rx_valid, 1'b1);
        chk8("rx_data_3", rx_data, 8'h56);
        chk1("wack_sda_3", sda_oe, 1'b0);
        rise(1'b1);
        do_stop();

        // Address NACK, then repeated START
        start_addr(7'h2A, 1'b0);
        send_byte("addr2A", 8'h54, S_RACK);
        rise(1'b1);
        chk1("nack_set", nack, 1'b1);
        fall(S_START);
        chk1("rs_nack_clr", nack, 1'b0);
        chk1("rs_st_ena0", st_ena, 1'b0);
        chk1("rs_sda0", sda_oe, 1'b0);
        rise(1'b1);
        chk1("rs_st_ena1", st_ena, 1'b1);
        chk1("rs_sda1", sda_oe, 1'b1);
        do_stop();

        // Async reset mid-WRITE at bit 3, then a clean transfer
        start_addr(7'h50, 1'b0);
        send_byte("addr50b", 8'hA0, S_RACK);
        rise(1'b0);
        tx_data = 8'hC3;
        fall(S_WR);
        for (int i = 0; i < 3; i++) begin rise(1'b0); fall(S_WR); end
        chk1("pre_rst_sda", sda_oe, 1'b1);
        chk1("pre_rst_cnt", counter, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_sda", sda_oe, 1'b0);
        chk1("arst_st_ena", st_ena, 1'b0);
        chk1("arst_stop_done", stop_done, 1'b0);
        chk1("arst_tx_req", tx_req, 1'b0);
        chk1("arst_rx_valid", rx_valid, 1'b0);
        chk1("arst_nack", nack, 1'b0);
        chk8("arst_rx_data", rx_data, 8'h00);
        state = S_IDOL;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        start_addr(7'h50, 1'b0);
        send_byte("addr50c", 8'hA0, S_RACK);
        rise(1'b0);
        tx_data = 8'h96;
        fall(S_WR);
        chk1("post_rst_tx_req", tx_req, 1'b1);
        send_byte("wr96", 8'h96, S_RACK1);
        rise(1'b0);
        chk1("post_rst_nack", nack, 1'b0);
        do_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
